// File: rtl/snake_dir_arbiter_pkg.sv
// Shared types for the snake direction arbiter: direction encoding, opposite(), button bit order.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam int unsigned NUM_BTN = 4;

  // Bit positions inside the Pending vector {U,D,L,R}
  localparam int unsigned BTN_U = 3;
  localparam int unsigned BTN_D = 2;
  localparam int unsigned BTN_L = 1;
  localparam int unsigned BTN_R = 0;

  function automatic dir_t opposite(dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

  function automatic logic [1:0] btn_bit(dir_t d);
    return 2'(2'd3 - 2'(d));
  endfunction

endpackage

// File: rtl/snake_dir_arbiter_if.sv
// Button/tick/run inputs and direction-stream outputs of snake_dir_arbiter.
// Drop_Count exists only when SNAKE_DIR_DROP_CNT_EN is defined.
interface snake_dir_arbiter_if
  import snake_pkg::*;
#(
  parameter int unsigned Q_DEPTH = 2
);
  localparam int unsigned QCW = $clog2(Q_DEPTH) + 1;

  logic           BtnU;
  logic           BtnD;
  logic           BtnL;
  logic           BtnR;
  logic           Tick;
  logic           Run;
  dir_t           Dir;
  logic           Dir_Strobe;
  logic [QCW-1:0] Q_Count;
  logic [3:0]     Pending;
`ifdef SNAKE_DIR_DROP_CNT_EN
  logic [7:0]     Drop_Count;
`endif

  modport master (
    output BtnU, BtnD, BtnL, BtnR, Tick, Run,
    input  Dir, Dir_Strobe, Q_Count, Pending
`ifdef SNAKE_DIR_DROP_CNT_EN
    , Drop_Count
`endif
  );

  modport slave (
    input  BtnU, BtnD, BtnL, BtnR, Tick, Run,
    output Dir, Dir_Strobe, Q_Count, Pending
`ifdef SNAKE_DIR_DROP_CNT_EN
    , Drop_Count
`endif
  );

endinterface

// File: rtl/snake_btn_debounce.sv
// One push button: 2-flop synchronizer, stability counter, and a one-cycle pulse on a
// debounced 0->1 transition.
module snake_btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned DEB_W      = 20
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the stable level; flip when the run is long enough
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/snake_dir_arbiter.sv
// Debounced, round-robin arbitrated, reversal-filtered direction FIFO for the snake core.
// Optional Drop_Count output enabled by defining SNAKE_DIR_DROP_CNT_EN.
module snake_dir_arbiter
  import snake_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned DEB_W      = 20,
  parameter int unsigned Q_DEPTH    = 2
) (
  input logic            Clk,
  input logic            Reset,
  snake_dir_arbiter_if.slave bus
);

  localparam int unsigned AW = $clog2(Q_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  assign btn_raw = {bus.BtnU, bus.BtnD, bus.BtnL, bus.BtnR};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    snake_btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .DEB_W      (DEB_W)
    ) u_deb (
      .Clk     (Clk),
      .Reset   (Reset),
      .btn_i   (btn_raw[i]),
      .press_o (press[i])
    );
  end

  dir_t               dir_q, dir_d;
  logic               strobe_q, strobe_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_BTN-1:0] pend_q, pend_d;
  dir_t               fifo_q [Q_DEPTH];
  dir_t               fifo_d [Q_DEPTH];
  logic [AW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [1:0]         ptr_q, ptr_d;

  logic               found, full, grant, discard, push, pop;
  logic [1:0]         idx;
  dir_t               gdir, tail;
  logic [NUM_BTN-1:0] clr;

  // Round-robin search over pending directions starting at the pointer
  always_comb begin
    found = 1'b0;
    gdir  = DIR_UP;
    idx   = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && pend_q[btn_bit(dir_t'(idx))]) begin
        found = 1'b1;
        gdir  = dir_t'(idx);
      end
    end
  end

  always_comb begin
    full    = (cnt_q == CW'(Q_DEPTH));
    tail    = (cnt_q != '0) ? fifo_q[wr_q - AW'(1)] : dir_q;
    grant   = bus.Run && found && !full;
    discard = grant && ((gdir == tail) || (gdir == opposite(tail)));
    push    = grant && !discard;
    pop     = bus.Run && bus.Tick && (cnt_q != '0);
    clr     = grant ? (4'b0001 << btn_bit(gdir)) : 4'b0000;
  end

  // Next state for FIFO, pointer, pending flags and committed direction
  always_comb begin
    fifo_d   = fifo_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    pend_d   = '0;
    dir_d    = dir_q;
    strobe_d = pop;
    if (pop) begin
      dir_d = fifo_q[rd_q];
    end
    if (bus.Run) begin
      pend_d = (pend_q & ~clr) | (press & ~pend_q);
      if (grant) begin
        ptr_d = 2'(gdir) + 2'd1;
      end
      if (push) begin
        fifo_d[wr_q] = gdir;
        wr_d         = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end else begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dir_q    <= DIR_RIGHT;
      strobe_q <= 1'b0;
      cnt_q    <= '0;
      pend_q   <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      ptr_q    <= '0;
      for (int i = 0; i < Q_DEPTH; i++) begin
        fifo_q[i] <= DIR_UP;
      end
    end else begin
      dir_q    <= dir_d;
      strobe_q <= strobe_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ptr_q    <= ptr_d;
      fifo_q   <= fifo_d;
    end
  end

  assign bus.Dir        = dir_q;
  assign bus.Dir_Strobe = strobe_q;
  assign bus.Q_Count    = cnt_q;
  assign bus.Pending    = pend_q;

`ifdef SNAKE_DIR_DROP_CNT_EN
  logic       run_q;
  logic [7:0] drop_q, drop_d;
  logic [2:0] drop_inc;
  logic [8:0] drop_sum;

  // Filtered discards plus presses absorbed by an already-set flag, saturating
  always_comb begin
    drop_inc = 3'($countones(bus.Run ? (press & pend_q) : 4'b0000)) + 3'(discard);
    drop_sum = {1'b0, drop_q} + 9'(drop_inc);
    drop_d   = drop_q;
    if (bus.Run && !run_q) begin
      drop_d = '0;
    end else if (bus.Run) begin
      drop_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      run_q  <= bus.Run;
      drop_q <= drop_d;
    end
  end

  assign bus.Drop_Count = drop_q;
`endif

endmodule

// File: tb/tb_snake_dir_arbiter.sv
// Randomized bench for snake_dir_arbiter with a queue-based reference model and directed anchors.
module tb_snake_dir_arbiter;
  import snake_pkg::*;

  localparam int unsigned DEB   = 4;
  localparam int unsigned DEPTH = 2;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  snake_dir_arbiter_if #(.Q_DEPTH(DEPTH)) bus ();

  snake_dir_arbiter #(
    .DEB_CYCLES (DEB),
    .DEB_W      (4),
    .Q_DEPTH    (DEPTH)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, indexed by direction (0=U 1=D 2=L 3=R)
  int m_dir;
  bit m_strobe;
  int m_q[$];
  bit m_pend[4];
  int m_ptr;
  int m_drop;
  bit m_run_prev;
  bit h0[4], h1[4], stab[4], prs[4];
  int run_len[4];

  function automatic bit pin(input int d);
    case (d)
      0: return bus.BtnU;
      1: return bus.BtnD;
      2: return bus.BtnL;
      default: return bus.BtnR;
    endcase
  endfunction

  task automatic model_reset();
    m_dir = 3; m_strobe = 0; m_q.delete(); m_ptr = 0; m_drop = 0; m_run_prev = 0;
    for (int d = 0; d < 4; d++) begin
      m_pend[d] = 0; h0[d] = 0; h1[d] = 0; stab[d] = 0; prs[d] = 0; run_len[d] = 0;
    end
  endtask

  task automatic model_step();
    bit run, tick, use_s, do_push;
    bit nprs[4];
    bit clr[4];
    int g, tail, d;
    run  = bus.Run;
    tick = bus.Tick;
    // Debounce: level accepted after DEB consecutive differing samples, samples lag the pin by 2
    for (int b = 0; b < 4; b++) begin
      use_s = h1[b];
      nprs[b] = 0;
      if (use_s != stab[b]) begin
        run_len[b]++;
        if (run_len[b] == DEB) begin
          stab[b] = use_s; run_len[b] = 0; nprs[b] = use_s;
        end
      end else begin
        run_len[b] = 0;
      end
      h1[b] = h0[b];
      h0[b] = pin(b);
    end
    m_strobe = 0;
    if (run) begin
      g = -1;
      do_push = 0;
      for (int b = 0; b < 4; b++) clr[b] = 0;
      if (m_q.size() < DEPTH) begin
        for (int k = 0; k < 4; k++) begin
          d = (m_ptr + k) % 4;
          if (g < 0 && m_pend[d]) g = d;
        end
      end
      tail = (m_q.size() > 0) ? m_q[$] : m_dir;
      if (g >= 0) begin
        clr[g] = 1;
        m_ptr = (g + 1) % 4;
        if (g == tail || g == (tail ^ 1)) m_drop++;
        else do_push = 1;
      end
      if (tick && m_q.size() > 0) begin
        m_dir = m_q.pop_front();
        m_strobe = 1;
      end
      if (do_push) m_q.push_back(g);
      for (int b = 0; b < 4; b++) begin
        if (prs[b] && m_pend[b]) m_drop++;
        m_pend[b] = (m_pend[b] && !clr[b]) || (prs[b] && !m_pend[b]);
      end
      if (m_drop > 255) m_drop = 255;
      if (!m_run_prev) m_drop = 0;
    end else begin
      m_q.delete();
      for (int b = 0; b < 4; b++) m_pend[b] = 0;
    end
    m_run_prev = run;
    for (int b = 0; b < 4; b++) prs[b] = nprs[b];
  endtask

  task automatic compare_all();
    logic [3:0] ep;
    for (int d = 0; d < 4; d++) ep[3-d] = m_pend[d];
    chk("dir", int'(bus.Dir), m_dir);
    chk("strobe", int'(bus.Dir_Strobe), int'(m_strobe));
    chk("q_count", int'(bus.Q_Count), m_q.size());
    chk("pending", int'(bus.Pending), int'(ep));
`ifdef SNAKE_DIR_DROP_CNT_EN
    chk("drop_count", int'(bus.Drop_Count), m_drop);
`endif
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      if (Reset) model_reset();
      else model_step();
      #1;
      compare_all();
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_tick();
    bus.Tick = 1'b1;
    cyc(1);
    bus.Tick = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    bus.BtnU = 0; bus.BtnD = 0; bus.BtnL = 0; bus.BtnR = 0;
    bus.Tick = 0; bus.Run = 0;
    cyc(3);
    chk("rst_dir", int'(bus.Dir), 3);
    chk("rst_strobe", int'(bus.Dir_Strobe), 0);
    chk("rst_qcount", int'(bus.Q_Count), 0);
    chk("rst_pending", int'(bus.Pending), 0);
    Reset = 1'b0;
    bus.Run = 1'b1;

    // Single UP press: pulse 6 cycles after the edge, pending next, pushed after that
    cyc(1);
    bus.BtnU = 1;
    cyc(6);
    chk("up_pend_early", int'(bus.Pending), 0);
    cyc(1);
    chk("up_pend", int'(bus.Pending), 4'b1000);
    cyc(1);
    chk("up_pushed", int'(bus.Q_Count), 1);
    chk("up_pend_clr", int'(bus.Pending), 0);
    cyc(2);
    bus.BtnU = 0;
    cyc(10);
    pulse_tick();
    chk("up_dir", int'(bus.Dir), 0);
    chk("up_strobe", int'(bus.Dir_Strobe), 1);
    cyc(1);
    chk("up_strobe_end", int'(bus.Dir_Strobe), 0);

    // Reversal discard from RIGHT
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    bus.BtnL = 1;
    cyc(7);
    chk("l_pend", int'(bus.Pending), 4'b0010);
    cyc(1);
    chk("l_discard_q", int'(bus.Q_Count), 0);
    chk("l_discard_p", int'(bus.Pending), 0);
`ifdef SNAKE_DIR_DROP_CNT_EN
    chk("l_drop", int'(bus.Drop_Count), 1);
`endif
    bus.BtnL = 0;
    cyc(10);

    // U and L together, then D held off by a full FIFO
    bus.BtnU = 1; bus.BtnL = 1;
    cyc(7);
    chk("ul_pend", int'(bus.Pending), 4'b1010);
    cyc(1);
    chk("ul_q1", int'(bus.Q_Count), 1);
    chk("ul_pend1", int'(bus.Pending), 4'b0010);
    cyc(1);
    chk("ul_q2", int'(bus.Q_Count), 2);
    bus.BtnU = 0; bus.BtnL = 0; bus.BtnD = 1;
    cyc(10);
    chk("d_held", int'(bus.Pending), 4'b0100);
    chk("d_full", int'(bus.Q_Count), 2);
    pulse_tick();
    chk("pop_u", int'(bus.Dir), 0);
    chk("pop_u_q", int'(bus.Q_Count), 1);
    cyc(1);
    chk("d_pushed", int'(bus.Q_Count), 2);
    chk("d_pend_clr", int'(bus.Pending), 0);
    bus.BtnD = 0;
    pulse_tick();
    chk("pop_l", int'(bus.Dir), 2);
    cyc(1);
    pulse_tick();
    chk("pop_d", int'(bus.Dir), 1);
    cyc(10);

    // Tick on empty FIFO, then push coinciding with Tick
    pulse_tick();
    chk("empty_dir", int'(bus.Dir), 1);
    chk("empty_strobe", int'(bus.Dir_Strobe), 0);
    bus.BtnL = 1;
    cyc(7);
    pulse_tick();
    chk("nobypass_q", int'(bus.Q_Count), 1);
    chk("nobypass_dir", int'(bus.Dir), 1);
    chk("nobypass_strobe", int'(bus.Dir_Strobe), 0);
    cyc(2);
    bus.BtnL = 0;
    pulse_tick();
    chk("later_dir", int'(bus.Dir), 2);
    chk("later_strobe", int'(bus.Dir_Strobe), 1);
    cyc(10);

    // Fill with U,R, hold L pending, then drop Run
    bus.BtnU = 1;
    cyc(8);
    bus.BtnU = 0; bus.BtnR = 1;
    cyc(8);
    chk("fill_q", int'(bus.Q_Count), 2);
    bus.BtnR = 0; bus.BtnL = 1;
    cyc(8);
    chk("fill_pend", int'(bus.Pending), 4'b0010);
    bus.Run = 0;
    cyc(1);
    chk("run0_q", int'(bus.Q_Count), 0);
    chk("run0_pend", int'(bus.Pending), 0);
    chk("run0_dir", int'(bus.Dir), 2);
    bus.Run = 1;
    cyc(10);
    chk("held_no_press", int'(bus.Pending), 0);
    bus.BtnL = 0;
    cyc(10);

    // Reset asserted while Dir_Strobe is high
    bus.BtnU = 1;
    cyc(8);
    bus.BtnU = 0;
    bus.Tick = 1;
    @(posedge Clk);
    #2;
    bus.Tick = 0;
    chk("mid_strobe", int'(bus.Dir_Strobe), 1);
    Reset = 1'b1;
    #1;
    chk("arst_dir", int'(bus.Dir), 3);
    chk("arst_strobe", int'(bus.Dir_Strobe), 0);
    cyc(2);
    Reset = 1'b0;

    // Random phase: bouncing buttons, random ticks, occasional Run drops and resets
    for (int n = 0; n < 4000; n++) begin
      cyc(1);
      if ($urandom_range(0, 15) == 0) bus.BtnU = ~bus.BtnU;
      if ($urandom_range(0, 15) == 0) bus.BtnD = ~bus.BtnD;
      if ($urandom_range(0, 15) == 0) bus.BtnL = ~bus.BtnL;
      if ($urandom_range(0, 15) == 0) bus.BtnR = ~bus.BtnR;
      bus.Tick = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 299) == 0) bus.Run = ~bus.Run;
      Reset = ($urandom_range(0, 1499) == 0);
    end
    Reset = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
